// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int REG_W           = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_MEM_TIMEOUT = 64;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazards, taken branches and SRAM waits.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_freeze,
  output logic             id_ex_flush,
  output logic             ex_mem_freeze,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] hazard_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic            m1, m2, hazard, mem_stall;
  logic            timeout_set;
  logic            hazard_inc;

  always_comb begin
    m1 = (exe_wb_en && (exe_dest == id_src1)) || (mem_wb_en && (mem_dest == id_src1));
    m2 = id_two_src &&
         ((exe_wb_en && (exe_dest == id_src2)) || (mem_wb_en && (mem_dest == id_src2)));
    // With forwarding only a load in EXE cannot be bypassed in time.
    if (fwd_en)
      hazard = exe_wb_en && exe_mem_r_en &&
               ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
    else
      hazard = m1 || m2;
    mem_stall = mem_req && !mem_ready;
  end

  always_comb begin
    pc_freeze     = 1'b0;
    if_id_freeze  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_freeze  = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_freeze = 1'b0;
    mem_wb_bubble = 1'b0;
    hazard_inc    = 1'b0;
    if (!rst) begin
      pc_freeze     = mem_stall || (hazard && !branch_taken);
      if_id_freeze  = pc_freeze;
      if_id_flush   = !mem_stall && branch_taken;
      id_ex_flush   = !mem_stall && (hazard || branch_taken);
      id_ex_freeze  = mem_stall;
      ex_mem_freeze = mem_stall;
      mem_wb_bubble = mem_stall;
      hazard_inc    = hazard && !mem_stall && !branch_taken;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    case (state)
      RUN: begin
        if (mem_stall)
          state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        wait_nxt = (wait_cnt == WC_W'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + 1'b1;
        if (mem_ready || !mem_req)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    timeout_set = (state == MEM_WAIT) && mem_stall && (wait_nxt == WC_W'(MEM_TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (timeout_set)
        mem_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(pc_freeze), .cnt(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(if_id_flush), .cnt(flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hazard_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(hazard_inc), .cnt(hazard_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus randomized bench for pipeline_ctrl against a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;
  localparam int MT    = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst, fwd_en, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic       branch_taken, mem_req, mem_ready, perf_clr;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush;
  logic       ex_mem_freeze, mem_wb_bubble, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, hazard_cnt;

  int checks   = 0;
  int failures = 0;

  int m_stall = 0, m_flush = 0, m_haz = 0, streak = 0;
  bit m_to = 1'b0;

  pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
    .id_ex_freeze(id_ex_freeze), .id_ex_flush(id_ex_flush),
    .ex_mem_freeze(ex_mem_freeze), .mem_wb_bubble(mem_wb_bubble),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .hazard_cnt(hazard_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; perf_clr = 1'b0; fwd_en = 1'b1;
    id_src1 = 4'd1; id_src2 = 4'd2; id_two_src = 1'b0;
    exe_dest = 4'd9; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'd10; mem_wb_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Applies current inputs for one clock: checks outputs mid-cycle, then advances the model.
  task automatic cycle();
    bit ex_hit1, ex_hit2, me_hit1, me_hit2, haz, stall, frz, iflush, xflush;
    #1;
    ex_hit1 = exe_wb_en && exe_dest == id_src1;
    ex_hit2 = id_two_src && exe_wb_en && exe_dest == id_src2;
    me_hit1 = mem_wb_en && mem_dest == id_src1;
    me_hit2 = id_two_src && mem_wb_en && mem_dest == id_src2;
    haz     = fwd_en ? (exe_mem_r_en && (ex_hit1 || ex_hit2))
                     : (ex_hit1 || ex_hit2 || me_hit1 || me_hit2);
    stall   = mem_req && !mem_ready;
    frz     = !rst && (stall || (haz && !branch_taken));
    iflush  = !rst && !stall && branch_taken;
    xflush  = !rst && !stall && (haz || branch_taken);
    chk("pc_freeze",     16'(pc_freeze),     16'(frz));
    chk("if_id_freeze",  16'(if_id_freeze),  16'(frz));
    chk("if_id_flush",   16'(if_id_flush),   16'(iflush));
    chk("id_ex_flush",   16'(id_ex_flush),   16'(xflush));
    chk("id_ex_freeze",  16'(id_ex_freeze),  16'(!rst && stall));
    chk("ex_mem_freeze", 16'(ex_mem_freeze), 16'(!rst && stall));
    chk("mem_wb_bubble", 16'(mem_wb_bubble), 16'(!rst && stall));
    chk("mem_timeout",   16'(mem_timeout),   16'(m_to));
    chk("stall_cnt",     16'(stall_cnt),     16'(m_stall));
    chk("flush_cnt",     16'(flush_cnt),     16'(m_flush));
    chk("hazard_cnt",    16'(hazard_cnt),    16'(m_haz));
    if (rst) begin
      m_stall = 0; m_flush = 0; m_haz = 0; streak = 0; m_to = 1'b0;
    end else begin
      streak = stall ? streak + 1 : 0;
      if (streak >= MT) m_to = 1'b1;
      if (perf_clr) begin
        m_stall = 0; m_flush = 0; m_haz = 0;
      end else begin
        if (frz)    m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (iflush) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        if (haz && !stall && !branch_taken) m_haz = (m_haz < CMAX) ? m_haz + 1 : CMAX;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    @(posedge clk); #1;

    // Reset dominates active stall and branch requests
    rst = 1'b1; mem_req = 1'b1; branch_taken = 1'b1;
    cycle(); cycle();
    idle(); cycle();
    chk("reset_stall_cnt", 16'(stall_cnt), 16'd0);

    // Load-use with forwarding: single-cycle freeze
    exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; id_src1 = 4'd3;
    cycle();
    idle(); cycle();
    chk("loaduse_hazard_cnt", 16'(hazard_cnt), 16'd1);

    // No-forward RAW through MEM on src2, then same with src2 unused
    fwd_en = 1'b0; mem_dest = 4'd5; mem_wb_en = 1'b1; id_src2 = 4'd5; id_two_src = 1'b1;
    cycle();
    chk("raw_src2_freeze_cnt", 16'(stall_cnt), 16'd2);
    id_two_src = 1'b0;
    cycle();
    chk("raw_nosrc2_freeze", 16'(stall_cnt), 16'd2);

    // Branch together with a hazard: flush, no freeze, hazard not counted
    idle(); perf_clr = 1'b1; cycle(); perf_clr = 1'b0;
    exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; id_src1 = 4'd3; branch_taken = 1'b1;
    cycle();
    chk("branch_flush_cnt", 16'(flush_cnt), 16'd1);
    chk("branch_hazard_cnt", 16'(hazard_cnt), 16'd0);

    // SRAM wait of 4 cycles with a branch pending; flush only once ready
    idle(); perf_clr = 1'b1; cycle(); perf_clr = 1'b0;
    mem_req = 1'b1; branch_taken = 1'b1;
    repeat (4) cycle();
    chk("sram_flush_held", 16'(flush_cnt), 16'd0);
    mem_ready = 1'b1;
    cycle();
    chk("sram_stall_cnt", 16'(stall_cnt), 16'd4);
    chk("sram_flush_after", 16'(flush_cnt), 16'd1);

    // Timeout after 8 consecutive stall cycles, sticky until rst
    idle(); mem_req = 1'b1;
    repeat (8) cycle();
    chk("timeout_raised", 16'(mem_timeout), 16'd1);
    cycle(); cycle();
    mem_ready = 1'b1; cycle();
    idle(); cycle(); cycle();
    chk("timeout_sticky", 16'(mem_timeout), 16'd1);
    rst = 1'b1; cycle();
    idle(); cycle();
    chk("timeout_cleared", 16'(mem_timeout), 16'd0);

    // Saturation with 20 hazard stalls, then clear beating an increment
    fwd_en = 1'b0; exe_dest = 4'd7; exe_wb_en = 1'b1; id_src1 = 4'd7;
    repeat (20) cycle();
    chk("sat_stall_cnt", 16'(stall_cnt), 16'(CMAX));
    perf_clr = 1'b1; cycle(); perf_clr = 1'b0;
    chk("clr_wins_stall", 16'(stall_cnt), 16'd0);
    chk("clr_wins_hazard", 16'(hazard_cnt), 16'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      perf_clr     = ($urandom_range(0, 39) == 0);
      fwd_en       = 1'($urandom);
      id_src1      = 4'($urandom_range(0, 3));
      id_src2      = 4'($urandom_range(0, 3));
      id_two_src   = 1'($urandom);
      exe_dest     = 4'($urandom_range(0, 3));
      exe_wb_en    = 1'($urandom);
      exe_mem_r_en = 1'($urandom);
      mem_dest     = 4'($urandom_range(0, 3));
      mem_wb_en    = 1'($urandom);
      branch_taken = ($urandom_range(0, 6) == 0);
      mem_req      = ($urandom_range(0, 2) == 0) || (mem_req && !mem_ready);
      mem_ready    = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
